// File: rtl/ysyx_22040088_pcctrl.sv
// rtl/ysyx_22040088_pcctrl.sv - PC sequencer: fetch handshake, next-PC select, halt/fault detection, retire count
module ysyx_22040088_pcctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [63:0] if_addr,
  input  logic        if_resp_valid,
  input  logic        if_resp_err,
  input  logic [31:0] if_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exe_done,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        is_blt,
  input  logic        is_bge,
  input  logic        br_taken,
  input  logic        is_ebreak,
  input  logic [63:0] nextpc,
  output logic [6:0]  sel_nextpc,
  output logic [63:0] pc,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      inst     <= '0;
      err_code <= 2'b00;
      instret  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (if_req_ready) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          // A response arriving on the last allowed cycle beats the timeout.
          if (if_resp_valid) begin
            if (if_resp_err) begin
              state    <= S_HALT;
              err_code <= 2'b01;
            end else begin
              inst  <= if_rdata;
              state <= S_EXEC;
            end
          end else if (wait_cnt == TO_LAST) begin
            state    <= S_HALT;
            err_code <= 2'b11;
          end
        end
        S_EXEC: begin
          if (exe_done) begin
            if (is_ebreak) begin
              instret  <= instret + 64'd1;
              state    <= S_HALT;
              err_code <= 2'b00;
            end else if (nextpc[1:0] != 2'b00) begin
              state    <= S_HALT;
              err_code <= 2'b10;
            end else begin
              pc      <= nextpc;
              instret <= instret + 64'd1;
              state   <= S_REQ;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign if_req_valid = (state == S_REQ);
  assign if_addr      = pc;
  assign inst_valid   = (state == S_EXEC);
  assign halted       = (state == S_HALT);

  always_comb begin
    sel_nextpc = 7'b0000001;
    if (state == S_EXEC) begin
      if (is_jal)                     sel_nextpc = 7'b0000010;
      else if (is_jalr)               sel_nextpc = 7'b0000100;
      else if (is_beq && br_taken)    sel_nextpc = 7'b0001000;
      else if (is_bne && br_taken)    sel_nextpc = 7'b0010000;
      else if (is_blt && br_taken)    sel_nextpc = 7'b0100000;
      else if (is_bge && br_taken)    sel_nextpc = 7'b1000000;
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_pcctrl.sv
// tb/tb_ysyx_22040088_pcctrl.sv - directed and randomized checks of the PC sequencer against a behavioural model
module tb_ysyx_22040088_pcctrl;

  localparam int TO = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_addr;
  logic        if_resp_valid, if_resp_err;
  logic [31:0] if_rdata, inst;
  logic        inst_valid, exe_done;
  logic        is_jal, is_jalr, is_beq, is_bne, is_blt, is_bge, br_taken, is_ebreak;
  logic [63:0] nextpc, pc, instret;
  logic [6:0]  sel_nextpc;
  logic        halted;
  logic [1:0]  err_code;

  ysyx_22040088_pcctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_err(if_resp_err), .if_rdata(if_rdata),
    .inst(inst), .inst_valid(inst_valid), .exe_done(exe_done),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_beq(is_beq), .is_bne(is_bne),
    .is_blt(is_blt), .is_bge(is_bge), .br_taken(br_taken), .is_ebreak(is_ebreak),
    .nextpc(nextpc), .sel_nextpc(sel_nextpc), .pc(pc), .halted(halted),
    .err_code(err_code), .instret(instret)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Behavioural model: phase of the fetch/execute loop plus architectural state.
  localparam int P_BOOT = 0, P_REQ = 1, P_WAIT = 2, P_EXEC = 3, P_HALT = 4;
  int          m_phase;
  int          m_waited;
  logic [63:0] m_pc, m_ret;
  logic [31:0] m_inst;
  logic [1:0]  m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_sel();
    int idx;
    idx = 0;
    if (m_phase != P_EXEC) return 7'b0000001;
    if (is_bge && br_taken) idx = 6;
    if (is_blt && br_taken) idx = 5;
    if (is_bne && br_taken) idx = 4;
    if (is_beq && br_taken) idx = 3;
    if (is_jalr)            idx = 2;
    if (is_jal)             idx = 1;
    return 7'(1 << idx);
  endfunction

  task automatic model_reset();
    m_phase = P_BOOT; m_waited = 0; m_pc = RPC; m_ret = '0; m_inst = '0; m_err = 2'b00;
  endtask

  task automatic model_step();
    case (m_phase)
      P_BOOT: m_phase = P_REQ;
      P_REQ:  if (if_req_ready) begin m_phase = P_WAIT; m_waited = 0; end
      P_WAIT: begin
        m_waited++;
        if (if_resp_valid && if_resp_err) begin m_phase = P_HALT; m_err = 2'b01; end
        else if (if_resp_valid) begin m_inst = if_rdata; m_phase = P_EXEC; end
        else if (m_waited == TO) begin m_phase = P_HALT; m_err = 2'b11; end
      end
      P_EXEC: if (exe_done) begin
        if (is_ebreak) begin m_ret = m_ret + 1; m_phase = P_HALT; m_err = 2'b00; end
        else if (nextpc % 4 != 0) begin m_phase = P_HALT; m_err = 2'b10; end
        else begin m_pc = nextpc; m_ret = m_ret + 1; m_phase = P_REQ; end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("if_req_valid", 64'(if_req_valid), 64'(m_phase == P_REQ));
    chk("if_addr", if_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst", 64'(inst), 64'(m_inst));
    chk("inst_valid", 64'(inst_valid), 64'(m_phase == P_EXEC));
    chk("sel_nextpc", 64'(sel_nextpc), 64'(exp_sel()));
    chk("halted", 64'(halted), 64'(m_phase == P_HALT));
    chk("err_code", 64'(err_code), 64'(m_err));
    chk("instret", instret, m_ret);
  endtask

  task automatic clear_in();
    if_req_ready = 0; if_resp_valid = 0; if_resp_err = 0; if_rdata = '0; exe_done = 0;
    is_jal = 0; is_jalr = 0; is_beq = 0; is_bne = 0; is_blt = 0; is_bge = 0;
    br_taken = 0; is_ebreak = 0; nextpc = '0;
  endtask

  // Inputs are set at the falling edge; compare, then let one rising edge pass.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  // From just after reset release: boot, accept, respond; ends at negedge in EXEC.
  task automatic to_exec(input logic [31:0] word);
    clear_in(); if_req_ready = 1;
    tick(); tick();
    if_resp_valid = 1; if_rdata = word;
    tick();
    clear_in();
  endtask

  initial begin
    clear_in();
    model_reset();
    rst_n = 0;
    @(negedge clk);
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_sel", 64'(sel_nextpc), 64'h1);
    chk("rst_instret", instret, 64'h0);
    chk("rst_req", 64'(if_req_valid), 64'h0);
    do_reset();

    // Two sequential instructions, 3 cycles each
    if_req_ready = 1;
    tick();
    chk("first_addr", if_addr, 64'h8000_0000);
    tick();
    if_resp_valid = 1; if_rdata = 32'h0000_0013;
    tick();
    clear_in(); exe_done = 1; nextpc = 64'h8000_0004;
    #1 chk("inst_latched", 64'(inst), 64'h13);
    tick();
    chk("second_addr", if_addr, 64'h8000_0004);
    clear_in(); if_req_ready = 1; tick();
    clear_in(); if_resp_valid = 1; if_rdata = 32'h0040_0093; tick();
    clear_in(); exe_done = 1; nextpc = 64'h8000_0008; tick();
    chk("instret_two", instret, 64'd2);

    // beq taken, beq not taken, jal+bne
    clear_in(); if_req_ready = 1; tick();
    clear_in(); if_resp_valid = 1; tick();
    clear_in(); exe_done = 1; is_beq = 1; br_taken = 1; nextpc = 64'h8000_0100;
    #1 chk("sel_beq_taken", 64'(sel_nextpc), 64'b0001000);
    tick();
    chk("beq_target", if_addr, 64'h8000_0100);
    clear_in(); if_req_ready = 1; tick();
    clear_in(); if_resp_valid = 1; tick();
    clear_in(); exe_done = 1; is_beq = 1; nextpc = 64'h8000_0104;
    #1 chk("sel_beq_nt", 64'(sel_nextpc), 64'b0000001);
    tick();
    clear_in(); if_req_ready = 1; tick();
    clear_in(); if_resp_valid = 1; tick();
    clear_in(); exe_done = 1; is_jal = 1; is_bne = 1; br_taken = 1; nextpc = 64'h8000_0200;
    #1 chk("sel_jal_bne", 64'(sel_nextpc), 64'b0000010);
    tick();

    // Fetch timeout: halt exactly TO cycles after entering the wait
    clear_in(); if_req_ready = 1; tick();
    clear_in();
    tick(); tick(); tick();
    chk("to_not_yet", 64'(halted), 64'h0);
    tick();
    chk("to_halted", 64'(halted), 64'h1);
    chk("to_err", 64'(err_code), 64'h3);
    tick(); tick();
    chk("halt_absorb", 64'(halted), 64'h1);

    // Response on the timeout cycle wins
    do_reset();
    clear_in(); if_req_ready = 1; tick(); tick();
    clear_in(); tick(); tick(); tick();
    if_resp_valid = 1; if_rdata = 32'hdead_beef; tick();
    chk("late_resp_exec", 64'(inst_valid), 64'h1);

    // Bus error
    do_reset();
    clear_in(); if_req_ready = 1; tick(); tick();
    clear_in(); if_resp_valid = 1; if_resp_err = 1; tick();
    chk("buserr_err", 64'(err_code), 64'h1);
    chk("buserr_ret", instret, 64'h0);

    // Misaligned target
    do_reset();
    to_exec(32'h1);
    exe_done = 1; nextpc = 64'h8000_0102; tick();
    chk("mis_err", 64'(err_code), 64'h2);
    chk("mis_pc", pc, 64'h8000_0000);

    // ebreak
    do_reset();
    to_exec(32'h0010_0073);
    exe_done = 1; is_ebreak = 1; nextpc = 64'h8000_0004; tick();
    chk("ebreak_halt", 64'(halted), 64'h1);
    chk("ebreak_err", 64'(err_code), 64'h0);
    chk("ebreak_ret", instret, 64'h1);

    // Reset pulsed while waiting for a response
    do_reset();
    to_exec(32'h13);
    exe_done = 1; nextpc = 64'h8000_0040; tick();
    clear_in(); if_req_ready = 1; tick();
    clear_in(); #2;
    do_reset();
    chk("rst_wait_pc", pc, 64'h8000_0000);
    if_resp_valid = 1; tick();
    chk("boot_to_req", 64'(if_req_valid), 64'h1);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      if_req_ready  = ($urandom % 2) == 0;
      if_resp_valid = ($urandom % 3) == 0;
      if_resp_err   = ($urandom % 16) == 0;
      if_rdata      = $urandom;
      exe_done      = ($urandom % 2) == 0;
      is_jal        = ($urandom % 4) == 0;
      is_jalr       = ($urandom % 4) == 0;
      is_beq        = ($urandom % 4) == 0;
      is_bne        = ($urandom % 4) == 0;
      is_blt        = ($urandom % 4) == 0;
      is_bge        = ($urandom % 4) == 0;
      br_taken      = ($urandom % 2) == 0;
      is_ebreak     = ($urandom % 32) == 0;
      nextpc        = {$urandom, $urandom} & ~64'h3;
      if (($urandom % 32) == 0) nextpc[1:0] = 2'($urandom_range(1, 3));
      if ((m_phase == P_HALT && ($urandom % 4) == 0) || ($urandom % 300) == 0)
        do_reset();
      else
        tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
